// File: rtl/tetris_input_pkg.sv
// rtl/tetris_input_pkg.sv - action codes, pending-mask priority order and default queue depth
package tetris_input_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int NUM_MASK      = 7;

  typedef enum logic [3:0] {
    ACT_NONE      = 4'd0,
    ACT_LEFT      = 4'd1,
    ACT_RIGHT     = 4'd2,
    ACT_ROTATE    = 4'd3,
    ACT_SOFT_DROP = 4'd4,
    ACT_HARD_DROP = 4'd5,
    ACT_HOLD      = 4'd6,
    ACT_PAUSE     = 4'd7,
    ACT_RESET     = 4'd8
  } action_t;

  // Highest priority first.
  localparam action_t PRIO_ORDER [NUM_MASK] = '{
    ACT_PAUSE, ACT_HARD_DROP, ACT_ROTATE, ACT_LEFT, ACT_RIGHT, ACT_SOFT_DROP, ACT_HOLD
  };

  // Mask bit i holds action code i+1; RESET never lives in the mask.
  localparam logic [NUM_MASK-1:0] MOVE_MASK = 7'b011_1111;

  function automatic logic [NUM_MASK-1:0] act_bit(input action_t a);
    logic [NUM_MASK-1:0] b;
    b = '0;
    case (a)
      ACT_LEFT:      b[0] = 1'b1;
      ACT_RIGHT:     b[1] = 1'b1;
      ACT_ROTATE:    b[2] = 1'b1;
      ACT_SOFT_DROP: b[3] = 1'b1;
      ACT_HARD_DROP: b[4] = 1'b1;
      ACT_HOLD:      b[5] = 1'b1;
      ACT_PAUSE:     b[6] = 1'b1;
      default:       b    = '0;
    endcase
    return b;
  endfunction

  // Walk from lowest to highest priority so the highest set bit wins last.
  function automatic action_t prio_pick(input logic [NUM_MASK-1:0] m);
    action_t r;
    r = ACT_NONE;
    for (int i = NUM_MASK - 1; i >= 0; i--) begin
      if ((m & act_bit(PRIO_ORDER[i])) != '0) r = PRIO_ORDER[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/action_fifo.sv
// rtl/action_fifo.sv - power-of-two action FIFO with single-cycle flush
module action_fifo
  import tetris_input_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = $bits(action_t)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop, do_push, wr_en;
  logic [AW-1:0]    wr_addr;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Next pointers; a flush restarts at slot 0 and may load one entry at once.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    wr_en   = do_push;
    wr_addr = wptr_q[AW-1:0];
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = push_i ? {{AW{1'b0}}, 1'b1} : '0;
      wr_en   = push_i;
      wr_addr = '0;
    end else begin
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push) wptr_d = wptr_q + 1'b1;
    end
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are don't-care until pointed at.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= push_data_i;
  end

endmodule

// File: rtl/action_queue.sv
// rtl/action_queue.sv - button pulses to prioritised, back-pressured action stream
module action_queue
  import tetris_input_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       reset_b,
  input  logic       pause_b,
  input  logic       left_b,
  input  logic       right_b,
  input  logic       rotate_b,
  input  logic       soft_drop_b,
  input  logic       hard_drop_b,
  input  logic       hold_b,
  input  logic       action_ready_in,
  output logic [3:0] action_out,
  output logic       action_valid_out,
  output logic       paused_out,
  output logic       overflow_out
);

  logic [NUM_MASK-1:0] mask_q, mask_d, pulse_v, accept, kept, push_bit;
  logic                paused_q, paused_d, ovf_q, ovf_d;
  logic                fifo_full, fifo_empty, pop, can_push;
  logic [3:0]          fifo_head, push_data;
  action_t             sel;

  assign pulse_v = {pause_b, hold_b, hard_drop_b, soft_drop_b, rotate_b, right_b, left_b};

  assign action_valid_out = ~fifo_empty;
  assign action_out       = fifo_empty ? ACT_NONE : fifo_head;
  assign paused_out       = paused_q;
  assign overflow_out     = ovf_q;

  assign pop       = action_valid_out & action_ready_in;
  assign sel       = prio_pick(mask_q);
  assign can_push  = (mask_q != '0) & (~fifo_full | pop);
  assign push_bit  = can_push ? act_bit(sel) : '0;
  assign push_data = reset_b ? ACT_RESET : sel;

  // Mask update, pause toggle and overflow detection; reset_b overrides all.
  always_comb begin
    accept = pulse_v;
    if (paused_q | pause_b) accept = accept & ~MOVE_MASK;
    kept = mask_q & ~push_bit;
    if (pause_b & ~paused_q) kept = kept & ~MOVE_MASK;
    mask_d   = kept | accept;
    paused_d = paused_q ^ pause_b;
    ovf_d    = ovf_q | (|(accept & kept));
    if (reset_b) begin
      mask_d   = '0;
      paused_d = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mask_q   <= '0;
      paused_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      paused_q <= paused_d;
      ovf_q    <= ovf_d;
    end
  end

  action_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk_i       (clk_in),
    .rst_i       (reset_in),
    .flush_i     (reset_b),
    .push_i      (reset_b | can_push),
    .push_data_i (push_data),
    .pop_i       (pop & ~reset_b),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_action_queue.sv
// tb/tb_action_queue.sv - self-checking bench for action_queue
module tb_action_queue;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       reset_b, pause_b, left_b, right_b, rotate_b, soft_drop_b, hard_drop_b, hold_b;
  logic       action_ready_in;
  logic [3:0] action_out;
  logic       action_valid_out, paused_out, overflow_out;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q [$];

  // Pulse bit order: 0 L, 1 R, 2 ROT, 3 SOFT, 4 HARD, 5 HOLD, 6 PAUSE, 7 RESET
  localparam logic [7:0] P_L = 8'h01, P_R = 8'h02, P_ROT = 8'h04, P_SOFT = 8'h08;
  localparam logic [7:0] P_HARD = 8'h10, P_HOLD = 8'h20, P_PAUSE = 8'h40, P_RST = 8'h80;

  typedef struct {
    logic [7:0] pulses;
    int         n;
    logic [3:0] exp [3];
  } vec_t;

  vec_t vecs [6];

  action_queue #(.DEPTH(8)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .reset_b          (reset_b),
    .pause_b          (pause_b),
    .left_b           (left_b),
    .right_b          (right_b),
    .rotate_b         (rotate_b),
    .soft_drop_b      (soft_drop_b),
    .hard_drop_b      (hard_drop_b),
    .hold_b           (hold_b),
    .action_ready_in  (action_ready_in),
    .action_out       (action_out),
    .action_valid_out (action_valid_out),
    .paused_out       (paused_out),
    .overflow_out     (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] p, input int n,
                         input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
    vecs[i].pulses = p;
    vecs[i].n      = n;
    vecs[i].exp[0] = e0;
    vecs[i].exp[1] = e1;
    vecs[i].exp[2] = e2;
  endtask

  task automatic drive(input logic [7:0] m);
    left_b      = m[0];
    right_b     = m[1];
    rotate_b    = m[2];
    soft_drop_b = m[3];
    hard_drop_b = m[4];
    hold_b      = m[5];
    pause_b     = m[6];
    reset_b     = m[7];
  endtask

  // Advance to just after the next rising edge, then present the new pulse set.
  task automatic step(input logic [7:0] m);
    @(posedge clk_in);
    #1;
    drive(m);
  endtask

  // Scoreboard: every accepted head must match the oldest expected action.
  always @(negedge clk_in) begin
    if (!reset_in && action_valid_out && action_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0d required=none", action_out);
      end else begin
        check("scoreboard", int'(action_out), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int waited;

    set_vec(0, P_L | P_ROT | P_HARD,   3, 4'd5, 4'd3, 4'd1);
    set_vec(1, P_R | P_SOFT,           2, 4'd2, 4'd4, 4'd0);
    set_vec(2, P_R | P_SOFT | P_HOLD,  3, 4'd2, 4'd4, 4'd6);
    set_vec(3, P_HARD | P_HOLD,        2, 4'd5, 4'd6, 4'd0);
    set_vec(4, P_L | P_ROT,            2, 4'd3, 4'd1, 4'd0);
    set_vec(5, P_SOFT,                 1, 4'd4, 4'd0, 4'd0);

    reset_in        = 1'b1;
    action_ready_in = 1'b0;
    drive(8'h00);
    #12;
    check("reset_valid",    int'(action_valid_out), 0);
    check("reset_action",   int'(action_out),       0);
    check("reset_paused",   int'(paused_out),       0);
    check("reset_overflow", int'(overflow_out),     0);
    @(negedge clk_in);
    reset_in = 1'b0;

    // Single left pulse: valid two edges after the pulse is presented, for one cycle.
    action_ready_in = 1'b1;
    step(P_L);
    exp_q.push_back(4'd1);
    step(8'h00);
    check("lat_valid_e1", int'(action_valid_out), 0);
    step(8'h00);
    check("lat_valid_e2", int'(action_valid_out), 1);
    check("lat_action_e2", int'(action_out), 1);
    step(8'h00);
    check("lat_valid_e3", int'(action_valid_out), 0);

    // Table: same-cycle pulse groups drain in priority order on consecutive cycles.
    foreach (vecs[i]) begin
      step(vecs[i].pulses);
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].exp[k]);
      for (int k = 0; k < vecs[i].n + 2; k++) step(8'h00);
      check("vec_drained", exp_q.size(), 0);
      check("vec_valid_low", int'(action_valid_out), 0);
    end

    // Back-pressure: 9 alternating pulses fill the FIFO plus one mask bit.
    action_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step((i % 2 == 0) ? P_L : P_R);
      exp_q.push_back((i % 2 == 0) ? 4'd1 : 4'd2);
    end
    step(P_R);
    exp_q.push_back(4'd2);
    step(P_R);
    check("bp_no_overflow_yet", int'(overflow_out), 0);
    step(8'h00);
    check("bp_overflow_set", int'(overflow_out), 1);
    check("bp_valid_held", int'(action_valid_out), 1);
    check("bp_head_left", int'(action_out), 1);
    action_ready_in = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      step(8'h00);
      waited++;
    end
    check("bp_drained", exp_q.size(), 0);
    step(8'h00);
    check("bp_valid_low", int'(action_valid_out), 0);
    check("bp_overflow_sticky", int'(overflow_out), 1);

    // reset_b with hold_b while 4 entries are queued: only RESET survives.
    action_ready_in = 1'b0;
    step(P_L | P_R | P_ROT | P_SOFT);
    for (int k = 0; k < 6; k++) step(8'h00);
    check("rb_fifo_loaded", int'(action_valid_out), 1);
    step(P_RST | P_HOLD);
    exp_q.delete();
    exp_q.push_back(4'd8);
    step(8'h00);
    check("rb_valid", int'(action_valid_out), 1);
    check("rb_action", int'(action_out), 8);
    check("rb_overflow_clear", int'(overflow_out), 0);
    action_ready_in = 1'b1;
    step(8'h00);
    check("rb_single_entry", int'(action_valid_out), 0);
    check("rb_drained", exp_q.size(), 0);

    // Pause with a same-cycle and a following left pulse: only PAUSE is queued.
    step(P_PAUSE | P_L);
    exp_q.push_back(4'd7);
    step(P_L);
    check("pause_entered", int'(paused_out), 1);
    for (int k = 0; k < 4; k++) step(8'h00);
    check("pause_drained", exp_q.size(), 0);
    check("pause_valid_low", int'(action_valid_out), 0);
    check("pause_no_overflow", int'(overflow_out), 0);
    step(P_PAUSE);
    exp_q.push_back(4'd7);
    step(8'h00);
    check("resume_paused", int'(paused_out), 0);
    for (int k = 0; k < 3; k++) step(8'h00);
    check("resume_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a cycle clears outputs at once.
    action_ready_in = 1'b0;
    step(P_PAUSE);
    for (int k = 0; k < 3; k++) step(8'h00);
    check("async_pre_valid", int'(action_valid_out), 1);
    check("async_pre_paused", int'(paused_out), 1);
    #2;
    reset_in = 1'b1;
    #1;
    check("async_valid", int'(action_valid_out), 0);
    check("async_action", int'(action_out), 0);
    check("async_paused", int'(paused_out), 0);
    @(negedge clk_in);
    reset_in = 1'b0;

    // Sampling resumes on the first edge after reset release.
    action_ready_in = 1'b1;
    step(P_HARD);
    exp_q.push_back(4'd5);
    for (int k = 0; k < 3; k++) step(8'h00);
    check("post_reset_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/action_queue.md
ACTION_QUEUE -- requirements
Module: action_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, >=2).
REQ-002 SHALL have clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have reset_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have reset_b, pause_b, left_b, right_b, rotate_b, soft_drop_b, hard_drop_b, hold_b  input  1 each  single-cycle pulses from button_processing.
REQ-005 SHALL have action_ready_in  input  1  game engine accepts head action this cycle.
REQ-006 SHALL have action_out  output  4  head action code (action_t).
REQ-007 SHALL have action_valid_out  output  1  FIFO non-empty.
REQ-008 SHALL have paused_out  output  1  current pause state.
REQ-009 SHALL have overflow_out  output  1  sticky: a pulse was lost.

Function
REQ-010 SHALL encode actions NONE=0, LEFT=1, RIGHT=2, ROTATE=3, SOFT_DROP=4, HARD_DROP=5, HOLD=6, PAUSE=7, RESET=8.
REQ-011 SHALL keep a pending mask (one bit per action 1..7); each sampled pulse ORs into its bit at that edge.
REQ-012 SHALL each cycle push the highest-priority set mask bit into the FIFO and clear it; priority PAUSE > HARD_DROP > ROTATE > LEFT > RIGHT > SOFT_DROP > HOLD.
REQ-013 SHALL permit a push when FIFO not full, or when full and a pop occurs that same cycle.
REQ-014 SHALL give latency pulse-edge to action_valid_out high of exactly 2 cycles when FIFO and mask are empty.
REQ-015 SHALL pop on action_valid_out & action_ready_in; action_out is head entry, NONE when empty.
REQ-016 SHALL hold mask bits while FIFO is full (back-pressure); a pulse arriving whose bit is already set SHALL set overflow_out.
REQ-017 SHALL on a sampled reset_b: flush FIFO and mask, clear overflow_out and paused_out, discard all other same-cycle pulses, and load a single RESET entry (action_valid_out high next cycle).
REQ-018 SHALL on a sampled pause_b toggle paused_out at that edge and set the PAUSE mask bit.
REQ-019 SHALL ignore movement pulses (LEFT..HOLD) while paused_out is high or in the cycle pause_b enters pause; those SHALL NOT set overflow_out.
REQ-020 SHALL clear pending movement mask bits when entering pause; already-queued FIFO entries remain.
REQ-021 SHALL treat a pause_b arriving while paused as resume (toggle low), queuing PAUSE again.
REQ-022 SHALL wrap FIFO pointers modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-023 SHALL on reset_in asynchronously clear FIFO pointers, mask, paused_out, overflow_out; action_valid_out=0, action_out=NONE.
REQ-024 SHALL resume sampling pulses on the first rising edge after reset_in deasserts.

Structure
REQ-025 SHALL place action_t enum, priority order and default DEPTH in package tetris_input_pkg.
REQ-026 SHALL implement storage as sub-module action_fifo (push/pop/flush/full/empty, single-cycle flush).
REQ-027 SHALL keep mask, priority select and pause logic in action_queue itself.

Verification
REQ-028 Single left_b pulse, ready=1 -> action_valid_out high 2 cycles later with action_out=1 for one cycle.
REQ-029 left_b, rotate_b, hard_drop_b same cycle, ready=1 -> outputs 5, 3, 1 on consecutive cycles.
REQ-030 ready=0, 9 distinct-cycle pulses of alternating left/right with DEPTH=8 -> 8 entries held, mask holds rest; second pending right pulse sets overflow_out=1; no entry lost from FIFO.
REQ-031 pause_b then left_b -> paused_out=1, only action 7 emitted, left dropped, overflow_out=0; second pause_b -> paused_out=0, action 7 again.
REQ-032 FIFO holding 4 entries, reset_b with hold_b same cycle -> next cycle exactly one entry, action_out=8; overflow_out=0.
REQ-033 reset_in asserted mid-stream between clock edges -> outputs clear immediately without waiting for clk_in.
